// File: rtl/xif_result_buffer.sv
// In-order result buffer between coprocessor issue and the XIF result interface.
// Slots are allocated at issue, filled by the FU, marked by commit/kill, and retired in order.
module xif_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    alloc_valid_i,
    output logic                    alloc_ready_o,
    input  logic [X_ID_WIDTH-1:0]   alloc_id_i,
    input  logic [4:0]              alloc_rd_i,
    input  logic                    fu_valid_i,
    input  logic [X_ID_WIDTH-1:0]   fu_id_i,
    input  logic [DATA_WIDTH-1:0]   fu_data_i,
    input  logic                    commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]   commit_id_i,
    input  logic                    commit_kill_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [X_ID_WIDTH-1:0]   result_id_o,
    output logic [4:0]              result_rd_o,
    output logic [DATA_WIDTH-1:0]   result_data_o,
    output logic                    result_we_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]      r_live;
    logic [DEPTH-1:0]      r_has_data;
    logic [DEPTH-1:0]      r_committed;
    logic [DEPTH-1:0]      r_killed;
    logic [X_ID_WIDTH-1:0] r_id   [DEPTH];
    logic [4:0]            r_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_alloc;
    logic                  w_head_kill;
    logic                  w_head_valid;
    logic                  w_pop;
    logic [DEPTH-1:0]      w_fu_hit;
    logic [DEPTH-1:0]      w_cm_hit;

    // Only live slots can match, so a slot allocated this cycle ignores same-cycle FU/commit.
    always_comb begin
        w_fu_hit = '0;
        w_cm_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fu_hit[i] = fu_valid_i && r_live[i] && (r_id[i] == fu_id_i);
            w_cm_hit[i] = commit_valid_i && r_live[i] && (r_id[i] == commit_id_i);
        end
    end

    assign alloc_ready_o = (r_count != CNT_W'(DEPTH));
    assign w_alloc       = alloc_valid_i && alloc_ready_o;
    assign w_head_kill   = r_live[r_head] && r_killed[r_head];
    assign w_head_valid  = r_live[r_head] && !r_killed[r_head] &&
                           r_committed[r_head] && r_has_data[r_head];
    assign w_pop         = w_head_kill || (w_head_valid && result_ready_i);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_live      <= '0;
            r_has_data  <= '0;
            r_committed <= '0;
            r_killed    <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_fu_hit[i]) begin
                    r_has_data[i] <= 1'b1;
                end
                if (w_cm_hit[i]) begin
                    if (commit_kill_i) begin
                        r_killed[i] <= 1'b1;
                    end else begin
                        r_committed[i] <= 1'b1;
                    end
                end
            end
            if (w_pop) begin
                r_live[r_head] <= 1'b0;
                r_head         <= r_head + PTR_W'(1);
            end
            // Allocation never targets the popped slot: tail==head with a live head means full.
            if (w_alloc) begin
                r_live[r_tail]      <= 1'b1;
                r_has_data[r_tail]  <= 1'b0;
                r_committed[r_tail] <= 1'b0;
                r_killed[r_tail]    <= 1'b0;
                r_tail              <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_id[r_tail] <= alloc_id_i;
            r_rd[r_tail] <= alloc_rd_i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_fu_hit[i]) begin
                r_data[i] <= fu_data_i;
            end
        end
    end

    assign result_valid_o = w_head_valid;
    assign result_we_o    = w_head_valid;
    assign result_id_o    = w_head_valid ? r_id[r_head]   : '0;
    assign result_rd_o    = w_head_valid ? r_rd[r_head]   : '0;
    assign result_data_o  = w_head_valid ? r_data[r_head] : '0;
    assign count_o        = r_count;

endmodule

// File: tb/tb_xif_result_buffer.sv
// Bench for xif_result_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and a drain.
module tb_xif_result_buffer;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int DW    = 32;

    logic           clk_i = 1'b0;
    logic           rst_n = 1'b0;
    logic           alloc_valid_i, alloc_ready_o;
    logic [IDW-1:0] alloc_id_i;
    logic [4:0]     alloc_rd_i;
    logic           fu_valid_i;
    logic [IDW-1:0] fu_id_i;
    logic [DW-1:0]  fu_data_i;
    logic           commit_valid_i, commit_kill_i;
    logic [IDW-1:0] commit_id_i;
    logic           result_valid_o, result_ready_i, result_we_o;
    logic [IDW-1:0] result_id_o;
    logic [4:0]     result_rd_o;
    logic [DW-1:0]  result_data_o;
    logic [2:0]     count_o;

    always #5 clk_i = ~clk_i;

    xif_result_buffer #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_id_i(alloc_id_i), .alloc_rd_i(alloc_rd_i),
        .fu_valid_i(fu_valid_i), .fu_id_i(fu_id_i), .fu_data_i(fu_data_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_data_o(result_data_o),
        .result_we_o(result_we_o), .count_o(count_o)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [4:0]     rd;
        logic [DW-1:0]  data;
        bit             has_data;
        bit             committed;
        bit             killed;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of in-flight instructions, advanced once per clock.
    initial begin
        bit             e_valid, pop;
        logic [IDW-1:0] e_id;
        logic [4:0]     e_rd;
        logic [DW-1:0]  e_data;
        int             n;
        ent_t           e;
        forever begin
            @(negedge clk_i);
            if (!rst_n) begin
                q.delete();
                chk("rst_valid", 64'(result_valid_o), 64'(0));
                chk("rst_count", 64'(count_o), 64'(0));
                chk("rst_ready", 64'(alloc_ready_o), 64'(1));
            end else begin
                n = q.size();
                e_valid = 1'b0; e_id = '0; e_rd = '0; e_data = '0;
                if (n > 0 && !q[0].killed && q[0].committed && q[0].has_data) begin
                    e_valid = 1'b1; e_id = q[0].id; e_rd = q[0].rd; e_data = q[0].data;
                end
                chk("m_valid", 64'(result_valid_o), 64'(e_valid));
                chk("m_we", 64'(result_we_o), 64'(e_valid));
                chk("m_id", 64'(result_id_o), 64'(e_id));
                chk("m_rd", 64'(result_rd_o), 64'(e_rd));
                chk("m_data", 64'(result_data_o), 64'(e_data));
                chk("m_count", 64'(count_o), 64'(n));
                chk("m_alloc_ready", 64'(alloc_ready_o), 64'(n < DEPTH));
                pop = (n > 0) && (q[0].killed || (e_valid && result_ready_i));
                for (int i = 0; i < n; i++) begin
                    e = q[i];
                    if (fu_valid_i && e.id == fu_id_i) begin
                        e.has_data = 1'b1;
                        e.data = fu_data_i;
                    end
                    if (commit_valid_i && e.id == commit_id_i) begin
                        if (commit_kill_i) e.killed = 1'b1;
                        else e.committed = 1'b1;
                    end
                    q[i] = e;
                end
                if (pop) void'(q.pop_front());
                if (alloc_valid_i && n < DEPTH) begin
                    e.id = alloc_id_i; e.rd = alloc_rd_i; e.data = '0;
                    e.has_data = 1'b0; e.committed = 1'b0; e.killed = 1'b0;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        alloc_valid_i = 1'b0; fu_valid_i = 1'b0; commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    endtask

    task automatic alloc(input logic [IDW-1:0] id, input logic [4:0] rd);
        alloc_valid_i = 1'b1; alloc_id_i = id; alloc_rd_i = rd;
    endtask

    task automatic fu(input logic [IDW-1:0] id, input logic [DW-1:0] d);
        fu_valid_i = 1'b1; fu_id_i = id; fu_data_i = d;
    endtask

    task automatic commit(input logic [IDW-1:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    endtask

    task automatic expect_result(input string name, input logic [IDW-1:0] id,
                                 input logic [4:0] rd, input logic [DW-1:0] d);
        chk({name, "_valid"}, 64'(result_valid_o), 64'(1));
        chk({name, "_we"}, 64'(result_we_o), 64'(1));
        chk({name, "_id"}, 64'(result_id_o), 64'(id));
        chk({name, "_rd"}, 64'(result_rd_o), 64'(rd));
        chk({name, "_data"}, 64'(result_data_o), 64'(d));
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (count_o != 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk({name, "_drained"}, 64'(count_o), 64'(0));
    endtask

    initial begin
        logic [IDW-1:0] nid, base, sid;
        logic [IDW-1:0] h_id;
        logic [4:0]     h_rd;
        logic [DW-1:0]  h_data;
        int             k;

        alloc_valid_i = 0; alloc_id_i = '0; alloc_rd_i = '0;
        fu_valid_i = 0; fu_id_i = '0; fu_data_i = '0;
        commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0;
        result_ready_i = 1'b1;

        repeat (3) @(negedge clk_i);
        chk("reset_id", 64'(result_id_o), 64'(0));
        chk("reset_data", 64'(result_data_o), 64'(0));
        #1 rst_n = 1'b1;
        tick();

        // Basic flow: alloc, FU data, commit.
        alloc(4'd3, 5'd5); tick();
        fu(4'd3, 32'hDEADBEEF); tick();
        chk("basic_pre_valid", 64'(result_valid_o), 64'(0));
        commit(4'd3, 1'b0); tick();
        expect_result("basic", 4'd3, 5'd5, 32'hDEADBEEF);
        tick();
        chk("basic_count", 64'(count_o), 64'(0));
        chk("basic_post_valid", 64'(result_valid_o), 64'(0));

        // Commit before data.
        alloc(4'd3, 5'd5); tick();
        commit(4'd3, 1'b0); tick();
        chk("cfirst_pre_valid", 64'(result_valid_o), 64'(0));
        fu(4'd3, 32'hDEADBEEF); tick();
        expect_result("cfirst", 4'd3, 5'd5, 32'hDEADBEEF);
        tick();

        // FU write and commit in the same cycle.
        alloc(4'd3, 5'd5); tick();
        fu(4'd3, 32'hDEADBEEF); commit(4'd3, 1'b0); tick();
        expect_result("same", 4'd3, 5'd5, 32'hDEADBEEF);
        tick();
        chk("same_count", 64'(count_o), 64'(0));

        // Kill id 1 before data; id 2 must follow.
        alloc(4'd1, 5'd10); tick();
        alloc(4'd2, 5'd11); tick();
        commit(4'd1, 1'b1); tick();
        chk("kill_head_valid", 64'(result_valid_o), 64'(0));
        fu(4'd2, 32'h12345678); commit(4'd2, 1'b0); tick();
        chk("kill_count", 64'(count_o), 64'(1));
        expect_result("kill", 4'd2, 5'd11, 32'h12345678);
        tick();
        fu(4'd1, 32'hBAD0BAD0); tick();
        chk("late_fu_count", 64'(count_o), 64'(0));
        chk("late_fu_valid", 64'(result_valid_o), 64'(0));

        // Backpressure: outputs held while ready is low.
        result_ready_i = 1'b0;
        alloc(4'd7, 5'd9); tick();
        fu(4'd7, 32'hCAFEF00D); commit(4'd7, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            expect_result("hold", 4'd7, 5'd9, 32'hCAFEF00D);
            tick();
        end
        result_ready_i = 1'b1;
        expect_result("hold_accept", 4'd7, 5'd9, 32'hCAFEF00D);
        tick();
        chk("hold_count", 64'(count_o), 64'(0));

        // Full, then retire, then wrap with a second batch.
        for (int b = 0; b < 2; b++) begin
            result_ready_i = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                alloc(4'(8 + 4 * b + i), 5'(20 + i)); tick();
            end
            chk("full_ready", 64'(alloc_ready_o), 64'(0));
            chk("full_count", 64'(count_o), 64'(4));
            alloc(4'd0, 5'd0); tick();
            chk("full_ignored_count", 64'(count_o), 64'(4));
            for (int i = DEPTH - 1; i >= 0; i--) begin
                fu(4'(8 + 4 * b + i), 32'(32'hA000 + i)); commit(4'(8 + 4 * b + i), 1'b0); tick();
            end
            expect_result("wrap_first", 4'(8 + 4 * b), 5'd20, 32'hA000);
            result_ready_i = 1'b1;
            drain("wrap");
        end

        // Asynchronous reset while the head is presenting.
        result_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alloc(4'(i), 5'(i + 1)); tick();
        end
        fu(4'd0, 32'h55AA55AA); commit(4'd0, 1'b0); tick();
        expect_result("prerst", 4'd0, 5'd1, 32'h55AA55AA);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(result_valid_o), 64'(0));
        chk("arst_count", 64'(count_o), 64'(0));
        chk("arst_ready", 64'(alloc_ready_o), 64'(1));
        @(negedge clk_i);
        #1 rst_n = 1'b1;
        result_ready_i = 1'b1;
        tick();

        // Randomized traffic against the model.
        nid = 4'd0;
        for (int c = 0; c < 1500; c++) begin
            base = nid;
            result_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                alloc(nid, 5'($urandom_range(0, 31)));
                if (q.size() < DEPTH) nid = nid + 4'd1;
            end
            if ($urandom_range(0, 2) != 0) begin
                fu(base - 4'd1 - 4'($urandom_range(0, 5)), $urandom);
            end
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, q.size() - 1);
                if (!q[k].committed && !q[k].killed) begin
                    sid = q[k].id;
                    commit(sid, ($urandom_range(0, 3) == 0));
                end
            end
            tick();
        end

        // Finish every outstanding entry and let it drain.
        result_ready_i = 1'b1;
        for (int r = 0; r < 2 * DEPTH; r++) begin
            if (q.size() > 0) begin
                k = $urandom_range(0, q.size() - 1);
                sid = q[k].id;
                fu(sid, $urandom);
                if (!q[k].committed && !q[k].killed) commit(sid, 1'b0);
            end
            tick();
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].has_data || (!q[i].committed && !q[i].killed)) begin
                    sid = q[i].id;
                    fu(sid, $urandom);
                    if (!q[i].committed && !q[i].killed) commit(sid, 1'b0);
                    break;
                end
            end
            tick();
        end
        drain("final");

        h_id = '0; h_rd = '0; h_data = '0;
        chk("final_valid", 64'(result_valid_o), 64'(0));
        chk("final_outputs", {result_id_o, result_rd_o, result_data_o}, {h_id, h_rd, h_data});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xif_result_buffer.md
Name: xif_result_buffer

Overview:
- In-order result reorder/commit buffer between the coprocessor issue logic and the core's XIF result interface.
- A slot is allocated per accepted offloaded instruction (id, rd) at issue time.
- The functional unit (e.g. AES32) writes data into the slot by id, and the commit interface marks the slot committed or killed.
- Committed results with data are presented to the core strictly in allocation order; killed entries are freed silently. This decouples FU completion, commit arrival and result_ready backpressure.

Parameters:
- DEPTH, 4, number of slots; power of two, >= 2.
- X_ID_WIDTH, 4, width of instruction id.
- DATA_WIDTH, 32, result data width (matches X_RFW_WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid_i  in  1  issue logic accepts an instruction; allocate a slot at tail.
- alloc_ready_o  out  1  slot available (count < DEPTH).
- alloc_id_i  in  X_ID_WIDTH  id of allocated instruction.
- alloc_rd_i  in  5  destination register address.
- fu_valid_i  in  1  FU result strobe (one cycle per result).
- fu_id_i  in  X_ID_WIDTH  id of FU result.
- fu_data_i  in  DATA_WIDTH  FU result value.
- commit_valid_i  in  1  XIF commit strobe.
- commit_id_i  in  X_ID_WIDTH  id being committed or killed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  head result valid.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  X_ID_WIDTH  head id.
- result_rd_o  out  5  head rd.
- result_data_o  out  DATA_WIDTH  head data.
- result_we_o  out  1  equals result_valid_o.
- count_o  out  $clog2(DEPTH)+1  live slot count.

Behaviour:
- Storage and reset:
  - Circular buffer with head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH) and count.
  - Per-slot fields: live, has_data, committed, killed, id, rd, data.
  - Reset: all slots not live, pointers 0, count_o=0, alloc_ready_o=1, result_valid_o=0, result_* = 0. Reset mid-operation discards all entries immediately.
- Allocation:
  - Occurs when alloc_valid_i && alloc_ready_o: slot[tail] is made live with has_data=committed=killed=0, and tail increments.
  - alloc_valid_i while full is ignored; the issuer must not assert it.
  - alloc_ready_o depends on registered count only; a same-cycle pop does not free a slot for a same-cycle alloc.
- FU write:
  - fu_valid_i sets has_data and data on the live slot whose id == fu_id_i.
  - If no live slot matches (entry already killed and freed), the result is discarded with no error.
- Commit:
  - commit_valid_i on the live slot with matching id sets committed (kill=0) or killed (kill=1).
  - No match: ignored.
  - A slot allocated in the same cycle is not yet live, so a same-id commit that cycle is ignored.
  - FU write and commit to the same slot in the same cycle both apply.
  - Live ids are unique; the core guarantees this.
- Head processing (one action per cycle, from registered state):
  - Head live && killed: slot freed, head++, count--, result_valid_o stays 0 that cycle. Any has_data value is ignored.
  - Head live && committed && has_data: result_valid_o=1, and result_id/rd/data are driven from the head slot.
  - On result_ready_i, the slot is freed and head++. While ready is low, all result outputs are held stable.
  - Otherwise result_valid_o=0 and the result outputs are 0.
- Timing paths:
  - result_valid_o has no combinational path from any input.
  - Latency: data and commit both registered by end of cycle N, slot at head → result_valid_o in cycle N+1.
- Count update:
  - count_o = count; +1 on alloc, −1 on pop or kill-drop.
  - Simultaneous alloc and pop leaves count unchanged.
- Wrap-around: pointers wrap from DEPTH-1 to 0; full = count==DEPTH, empty = count==0.
- Ordering: a younger committed entry never overtakes an older non-ready entry (head-of-line blocking is intended).

Test Plan:
- Basic flow: reset; alloc id=3 rd=5; fu id=3 data=0xDEADBEEF; commit id=3 kill=0; ready=1 → result_valid the cycle after the last event, with id=3, rd=5, data=0xDEADBEEF, we=1; count returns to 0.
- Order independence: same transaction with commit before the FU data, then with FU and commit in the same cycle → identical output, one cycle after the last event.
- Kill: alloc ids 1,2; kill id 1 before data; commit and write id 2 → id 1 never appears, id 2 is output.
  - Late FU data for id 1 is discarded and count_o stays correct.
- Backpressure: result_ready_i low for 5 cycles → result_valid, id, rd and data held stable; accepted on the first ready=1 cycle.
- Full and wrap: alloc 4 entries → alloc_ready_o=0, count_o=4; retire all, then alloc 4 more → pointers wrap and results emerge in order with correct ids.
- Reset mid-operation: 3 live entries, head presenting a valid result; assert rst_n low asynchronously → result_valid_o=0 and count_o=0 immediately, alloc_ready_o=1.
